// File: rtl/vga_timing_out.sv
// 640x480@60 VGA timing generator with a registered, blanked colour/sync output stage.
// Counters advance once per pixel period; colour and sync lag the counters by one pixel.
module vga_timing_out #(
    parameter int unsigned CLK_DIV  = 4,
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [4:0]  rgb_in,
    output logic        pixel_tick,
    output logic [10:0] pixel_x,
    output logic [10:0] pixel_y,
    output logic        video_on,
    output logic [1:0]  frame_tick,
    output logic        frame_start,
    output logic        hsync,
    output logic        vsync,
    output logic [4:0]  vga_rgb
);

    localparam int unsigned CW      = 11;
    localparam int unsigned RGB_W   = 5;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CW-1:0]    H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0]    V_LAST   = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0]    H_ACT    = CW'(H_ACTIVE);
    localparam logic [CW-1:0]    V_ACT    = CW'(V_ACTIVE);
    localparam logic [CW-1:0]    HS_FIRST = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0]    HS_LAST  = CW'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CW-1:0]    VS_FIRST = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0]    VS_LAST  = CW'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;
    logic [CW-1:0]    x_q, x_d;
    logic [CW-1:0]    y_q, y_d;
    logic [1:0]       ft_q, ft_d;
    logic             fs_q, fs_d;
    logic             hs_q, hs_d;
    logic             vs_q, vs_d;
    logic [RGB_W-1:0] rgb_q, rgb_d;
    logic             vid_on;

    assign vid_on = (x_q < H_ACT) && (y_q < V_ACT);

    // State register: async reset, all outputs inactive and counters at the origin.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            ft_q   <= '0;
            fs_q   <= 1'b0;
            hs_q   <= 1'b1;
            vs_q   <= 1'b1;
            rgb_q  <= '0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
            x_q    <= x_d;
            y_q    <= y_d;
            ft_q   <= ft_d;
            fs_q   <= fs_d;
            hs_q   <= hs_d;
            vs_q   <= vs_d;
            rgb_q  <= rgb_d;
        end
    end

    // Next state: pixel_tick is high while div sits at its last count, so the
    // counter/output update lands on the edge that ends that clk.
    always_comb begin
        div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        tick_d = (div_d == DIV_LAST);
        x_d    = x_q;
        y_d    = y_q;
        ft_d   = ft_q;
        fs_d   = 1'b0;
        hs_d   = hs_q;
        vs_d   = vs_q;
        rgb_d  = rgb_q;
        if (tick_q) begin
            hs_d  = ~((x_q >= HS_FIRST) && (x_q <= HS_LAST));
            vs_d  = ~((y_q >= VS_FIRST) && (y_q <= VS_LAST));
            rgb_d = vid_on ? rgb_in : '0;
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    ft_d = ft_q + 2'd1;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + CW'(1);
                end
            end else begin
                x_d = x_q + CW'(1);
            end
        end
    end

    assign pixel_tick  = tick_q;
    assign pixel_x     = x_q;
    assign pixel_y     = y_q;
    assign video_on    = vid_on;
    assign frame_tick  = ft_q;
    assign frame_start = fs_q;
    assign hsync       = hs_q;
    assign vsync       = vs_q;
    assign vga_rgb     = rgb_q;

endmodule

// File: tb/tb_vga_timing_out.sv
// Directed bench for vga_timing_out on a shrunken raster (16x9 total, 8x4 active)
// with the full-rate divider, so several whole frames fit in a short run.
module tb_vga_timing_out;

    localparam int unsigned CD = 4;
    localparam int unsigned HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int unsigned VA = 4, VF = 1, VS = 2, VB = 2;
    localparam int unsigned HT = 16, VT = 9;
    // hsync low for x 10..12, vsync low for y 5..6
    localparam int unsigned HS0 = 10, HS1 = 12, VS0 = 5, VS1 = 6;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [4:0]  rgb_in;
    logic        pixel_tick;
    logic [10:0] pixel_x;
    logic [10:0] pixel_y;
    logic        video_on;
    logic [1:0]  frame_tick;
    logic        frame_start;
    logic        hsync;
    logic        vsync;
    logic [4:0]  vga_rgb;

    vga_timing_out #(
        .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .reset_n(reset_n), .rgb_in(rgb_in),
        .pixel_tick(pixel_tick), .pixel_x(pixel_x), .pixel_y(pixel_y),
        .video_on(video_on), .frame_tick(frame_tick), .frame_start(frame_start),
        .hsync(hsync), .vsync(vsync), .vga_rgb(vga_rgb)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int ex, ey, eft;
    int since_fs;
    bit fs_seen;
    int fs_idx;
    int rgb_mode;
    logic [4:0] rgb_cur;
    int ft_seq [8] = '{1, 2, 3, 0, 1, 2, 3, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive_rgb();
        if (rgb_mode == 0) rgb_in = 5'h1f;
        else               rgb_in = 5'((ex * 3 + ey * 7 + eft * 5 + 1) % 32);
        rgb_cur = rgb_in;
    endtask

    // Advance one pixel period and compare every output against the reference.
    task automatic adv_pix();
        int  n;
        bit  got;
        int  px, py, eft_prev;
        logic [31:0] exp_rgb, exp_hs, exp_vs, exp_fs;
        n = 0;
        got = 1'b0;
        for (int i = 0; i < 2 * CD; i++) begin
            @(posedge clk); #1;
            n++;
            if (pixel_tick === 1'b1) begin
                got = 1'b1;
                break;
            end
            chk("hold_x", 32'(pixel_x), 32'(ex));
            chk("hold_rgb", 32'(vga_rgb), 32'(dut.vga_rgb));
        end
        if (!got) begin
            chk("tick_timeout", 32'(0), 32'(1));
            return;
        end
        @(posedge clk); #1;
        n++;
        chk("pix_period", 32'(n), 32'(CD));
        px = ex;
        py = ey;
        eft_prev = eft;
        exp_rgb = (px < HA && py < VA) ? 32'(rgb_cur) : 32'(0);
        exp_hs  = (px >= HS0 && px <= HS1) ? 32'(0) : 32'(1);
        exp_vs  = (py >= VS0 && py <= VS1) ? 32'(0) : 32'(1);
        exp_fs  = (px == HT - 1 && py == VT - 1) ? 32'(1) : 32'(0);
        ex = (px + 1) % HT;
        if (px == HT - 1) begin
            ey = (py + 1) % VT;
            if (py == VT - 1) eft = (eft + 1) % 4;
        end
        chk("pixel_x", 32'(pixel_x), 32'(ex));
        chk("pixel_y", 32'(pixel_y), 32'(ey));
        chk("frame_tick", 32'(frame_tick), 32'(eft));
        chk("frame_start", 32'(frame_start), exp_fs);
        chk("hsync", 32'(hsync), exp_hs);
        chk("vsync", 32'(vsync), exp_vs);
        chk("vga_rgb", 32'(vga_rgb), exp_rgb);
        chk("video_on", 32'(video_on), (ex < HA && ey < VA) ? 32'(1) : 32'(0));
        chk("tick_low", 32'(pixel_tick), 32'(0));
        chk("ft_vs_fs", 32'(eft != eft_prev), 32'(frame_start));
        since_fs++;
        if (exp_fs == 32'(1)) begin
            if (fs_seen) chk("frame_len", 32'(since_fs), 32'(HT * VT));
            if (fs_idx < 8) chk("ft_seq", 32'(frame_tick), 32'(ft_seq[fs_idx]));
            fs_idx++;
            fs_seen = 1'b1;
            since_fs = 0;
        end
        drive_rgb();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_tick"}, 32'(pixel_tick), 32'(0));
        chk({tag, "_x"}, 32'(pixel_x), 32'(0));
        chk({tag, "_y"}, 32'(pixel_y), 32'(0));
        chk({tag, "_ft"}, 32'(frame_tick), 32'(0));
        chk({tag, "_fs"}, 32'(frame_start), 32'(0));
        chk({tag, "_hs"}, 32'(hsync), 32'(1));
        chk({tag, "_vs"}, 32'(vsync), 32'(1));
        chk({tag, "_rgb"}, 32'(vga_rgb), 32'(0));
        chk({tag, "_von"}, 32'(video_on), 32'(1));
    endtask

    initial begin
        reset_n  = 1'b0;
        rgb_in   = 5'h1f;
        rgb_cur  = 5'h1f;
        rgb_mode = 0;
        ex = 0; ey = 0; eft = 0;
        since_fs = 0; fs_seen = 1'b0; fs_idx = 0;

        // Reset held: everything at reset values
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("rst");

        // Release: tick appears with the 3rd edge (4th clk), update on the 4th edge
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("tick_e1", 32'(pixel_tick), 32'(0));
        @(posedge clk); #1;
        chk("tick_e2", 32'(pixel_tick), 32'(0));
        @(posedge clk); #1;
        chk("tick_e3", 32'(pixel_tick), 32'(1));
        chk("x_e3", 32'(pixel_x), 32'(0));
        @(posedge clk); #1;
        chk("tick_e4", 32'(pixel_tick), 32'(0));
        chk("x_e4", 32'(pixel_x), 32'(1));
        chk("rgb_e4", 32'(vga_rgb), 32'(31));
        chk("hs_e4", 32'(hsync), 32'(1));
        ex = 1;

        // First frame with white input, then a varying colour pattern
        for (int i = 0; i < HT * VT; i++) adv_pix();
        rgb_mode = 1;
        drive_rgb();
        for (int i = 0; i < 4 * HT * VT + HT; i++) adv_pix();
        chk("fs_count", 32'(fs_idx), 32'(5));

        // Run to pixel (5,2) in a frame with frame_tick==2, then reset mid-frame
        for (int i = 0; i < 4 * HT * VT; i++) begin
            if (ex == 5 && ey == 2 && eft == 2) break;
            adv_pix();
        end
        chk("pre_rst_x", 32'(pixel_x), 32'(5));
        chk("pre_rst_y", 32'(pixel_y), 32'(2));
        chk("pre_rst_ft", 32'(frame_tick), 32'(2));
        #3;
        reset_n = 1'b0;
        #1;
        chk_reset_vals("async");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        ex = 0; ey = 0; eft = 0;
        since_fs = 0; fs_seen = 1'b0;
        rgb_mode = 0;
        drive_rgb();
        for (int i = 0; i < 2 * HT + 3; i++) adv_pix();
        chk("restart_y", 32'(pixel_y), 32'(2));
        chk("restart_ft", 32'(frame_tick), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
Name: vga_timing_out

Overview:
- Display-side end of the pixel interface consumed by the screen renderers (title, game, end screens).
- Generates 640x480@60 VGA timing from the system clock and drives pixel_x, pixel_y, video_on and frame_tick to the renderers.
- Registers the renderer's 5-bit colour result together with hsync/vsync, so colour and sync leave the FPGA aligned and blanked correctly.

Parameters:
CLK_DIV, 4, system clocks per pixel (100 MHz -> 25 MHz); legal values >= 2
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch in pixels
H_SYNC, 96, hsync pulse width in pixels
H_BP, 48, horizontal back porch in pixels
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch in lines
V_SYNC, 2, vsync pulse width in lines
V_BP, 33, vertical back porch in lines

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
rgb_in  in  5  colour from the renderer for the current (pixel_x, pixel_y)
pixel_tick  out  1  one-clk pulse per pixel period
pixel_x  out  11  horizontal counter, 0..H_TOTAL-1
pixel_y  out  11  vertical counter, 0..V_TOTAL-1
video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
frame_tick  out  2  frame counter, modulo 4 (drives the flicker effect)
frame_start  out  1  one-clk pulse when the counters wrap to (0,0)
hsync  out  1  horizontal sync to the connector, active low
vsync  out  1  vertical sync to the connector, active low
vga_rgb  out  5  registered, blanked colour to the connector

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Reset (async assert, sync release): div=0, pixel_x=0, pixel_y=0, frame_tick=0, pixel_tick=0, frame_start=0, hsync=1, vsync=1, vga_rgb=0.
- Divider:
  - div counts 0..CLK_DIV-1 and wraps.
  - pixel_tick is registered and is high for exactly the clk in which div==CLK_DIV-1.
  - The first pixel_tick after reset release occurs CLK_DIV clks later.
- Counter update happens on a clk edge where pixel_tick==1:
  - pixel_x increments. At H_TOTAL-1 it wraps to 0 and pixel_y increments.
  - pixel_y wraps from V_TOTAL-1 to 0.
  - On the (H_TOTAL-1, V_TOTAL-1) -> (0,0) wrap, frame_tick increments (3 wraps to 0), and frame_start pulses for the following clk only.
- video_on is combinational from the pixel_x/pixel_y registers. It is valid for the whole pixel period, so renderers may be purely combinational.
- Output stage, updated on the same pixel_tick edges as the counters:
  - vga_rgb <= video_on ? rgb_in : 0, using pre-update values.
  - hsync <= ~(pixel_x in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]), i.e. low for pixel_x 656..751.
  - vsync <= ~(pixel_y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1]), i.e. low for pixel_y 490..491.
  - Consequence: vga_rgb, hsync and vsync lag the counters by exactly one pixel period and are mutually aligned.
- Between pixel_ticks all outputs hold.
- vga_rgb is never nonzero outside the active region, regardless of rgb_in.
- Reset mid-frame: all state returns immediately to reset values; the timing restarts at (0,0) with frame_tick=0.
- No other inputs exist; there are no stall or simultaneous-event cases beyond the h/v/frame wrap coinciding, which must all occur on the same tick.

Test Plan:
- Reset then release -> all outputs at reset values; first pixel_tick 4 clks after release; pixel_tick period exactly 4 clks thereafter.
- Free-run one line -> pixel_x counts 0..799 then 0; pixel_y increments once; hsync low for 96 consecutive pixel periods (384 clks), starting one pixel after pixel_x==656.
- Free-run one frame -> 525 lines, 420000 pixel_ticks (1,680,000 clks) between frame_start pulses; vsync low for 2 lines (1600 pixel periods), starting after pixel_y==490.
- Hold rgb_in=5'b11111 -> vga_rgb=11111 only for pixels whose counters were (x<640, y<480), one pixel later; 0 at pixel_x=640..799 and lines 480..524.
- Free-run 5 frames -> frame_tick sequence 0,1,2,3,0,1; each change coincides with a frame_start pulse.
- Assert reset_n low at pixel (300,200) with frame_tick=2 -> outputs return to reset values asynchronously; after release, counting restarts at (0,0) with frame_tick=0.
